// File: rtl/hazard_pkg.sv
// Shared stage-tag types and bubble constants for the hazard tag pipeline.
package hazard_pkg;

  localparam int REG_ADDR_W = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] ra1;
    logic [REG_ADDR_W-1:0] ra2;
    logic [REG_ADDR_W-1:0] wa3;
    logic                  reg_write;
    logic                  mem_to_reg;
  } tag_e_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wa3;
    logic                  reg_write;
    logic                  mem_to_reg;
  } tag_m_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wa3;
    logic                  reg_write;
  } tag_w_t;

  localparam tag_e_t TAG_E_BUBBLE = '0;
  localparam tag_m_t TAG_M_BUBBLE = '0;
  localparam tag_w_t TAG_W_BUBBLE = '0;

endpackage

// File: rtl/hazard_tag_cmp.sv
// Valid-gated register-address comparator: fires when either source address
// equals the destination and both sides hold real instructions.
module hazard_tag_cmp
  import hazard_pkg::*;
#(
  parameter int W = REG_ADDR_W
) (
  input  logic         src_valid_i,
  input  logic [W-1:0] src_a_i,
  input  logic [W-1:0] src_b_i,
  input  logic         dst_valid_i,
  input  logic [W-1:0] dst_i,
  output logic         match_o
);

  // Single-source users tie src_b_i to src_a_i.
  assign match_o = src_valid_i & dst_valid_i & ((src_a_i == dst_i) | (src_b_i == dst_i));

endmodule

// File: rtl/hazard_match_pipe.sv
// Register-tag pipeline feeding the hazard unit (D -> E -> M -> W).
// Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_match_pipe #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] WA3D,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  LDRstall,
  input  logic                  BranchTakenE,
  output logic                  Match_1E_M,
  output logic                  Match_1E_W,
  output logic                  Match_2E_M,
  output logic                  Match_2E_W,
  output logic                  Match_12D_E,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic                  MemtoRegE,
  output logic                  StallF,
  output logic                  StallD,
`ifdef HAZARD_STALL_CNT_EN
  output logic [15:0]           StallCount,
`endif
  output logic                  FlushE
);

  import hazard_pkg::*;

  tag_e_t e_q, e_d;
  tag_m_t m_q, m_d;
  tag_w_t w_q, w_d;

  assign StallF = LDRstall;
  assign StallD = LDRstall;
  assign FlushE = LDRstall | BranchTakenE;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    e_d = TAG_E_BUBBLE;
    if (!FlushE) begin
      e_d.valid      = ValidD;
      e_d.ra1        = RA1D;
      e_d.ra2        = RA2D;
      e_d.wa3        = WA3D;
      e_d.reg_write  = RegWriteD & ValidD;
      e_d.mem_to_reg = MemtoRegD & ValidD;
    end
    m_d = '{valid: e_q.valid, wa3: e_q.wa3, reg_write: e_q.reg_write,
            mem_to_reg: e_q.mem_to_reg};
    w_d = '{valid: m_q.valid, wa3: m_q.wa3, reg_write: m_q.reg_write};
  end

  // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= TAG_E_BUBBLE;
      m_q <= TAG_M_BUBBLE;
      w_q <= TAG_W_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign RegWriteM = m_q.reg_write;
  assign RegWriteW = w_q.reg_write;
  assign MemtoRegE = e_q.mem_to_reg;

  // MemtoRegM travels with the datapath but nothing in this block consumes it.
  logic unused_mem_to_reg_m;
  assign unused_mem_to_reg_m = m_q.mem_to_reg;

  hazard_tag_cmp #(.W(REG_ADDR_W)) u_cmp_1e_m (
    .src_valid_i(e_q.valid), .src_a_i(e_q.ra1), .src_b_i(e_q.ra1),
    .dst_valid_i(m_q.valid), .dst_i(m_q.wa3), .match_o(Match_1E_M)
  );

  hazard_tag_cmp #(.W(REG_ADDR_W)) u_cmp_1e_w (
    .src_valid_i(e_q.valid), .src_a_i(e_q.ra1), .src_b_i(e_q.ra1),
    .dst_valid_i(w_q.valid), .dst_i(w_q.wa3), .match_o(Match_1E_W)
  );

  hazard_tag_cmp #(.W(REG_ADDR_W)) u_cmp_2e_m (
    .src_valid_i(e_q.valid), .src_a_i(e_q.ra2), .src_b_i(e_q.ra2),
    .dst_valid_i(m_q.valid), .dst_i(m_q.wa3), .match_o(Match_2E_M)
  );

  hazard_tag_cmp #(.W(REG_ADDR_W)) u_cmp_2e_w (
    .src_valid_i(e_q.valid), .src_a_i(e_q.ra2), .src_b_i(e_q.ra2),
    .dst_valid_i(w_q.valid), .dst_i(w_q.wa3), .match_o(Match_2E_W)
  );

  hazard_tag_cmp #(.W(REG_ADDR_W)) u_cmp_12d_e (
    .src_valid_i(ValidD), .src_a_i(RA1D), .src_b_i(RA2D),
    .dst_valid_i(e_q.valid), .dst_i(e_q.wa3), .match_o(Match_12D_E)
  );

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating: holds at 0xFFFF instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (LDRstall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Self-checking bench for hazard_match_pipe: directed vector table, then
// randomized traffic against a stage-history reference model.
module tb_hazard_match_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       ValidD, RegWriteD, MemtoRegD, LDRstall, BranchTakenE;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic       RegWriteM, RegWriteW, MemtoRegE, StallF, StallD, FlushE;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  always #5 clk = ~clk;

  hazard_match_pipe dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .LDRstall(LDRstall), .BranchTakenE(BranchTakenE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .StallF(StallF), .StallD(StallD),
`ifdef HAZARD_STALL_CNT_EN
    .StallCount(StallCount),
`endif
    .FlushE(FlushE)
  );

  // Output order: {m1m,m1w,m2m,m2w}_{m12de,rwm,rww,mre}_{stallf,stalld,flushe}
  logic [10:0] outs;
  assign outs = {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
                 Match_12D_E, RegWriteM, RegWriteW, MemtoRegE,
                 StallF, StallD, FlushE};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: history of the last three instructions that left Decode,
  // stored raw; bubbles are records with v=0.
  typedef struct packed {
    logic       v;
    logic [3:0] ra1, ra2, wa3;
    logic       rw, mr;
  } ins_t;

  ins_t        hist[3];  // [0]=Execute, [1]=Memory, [2]=Writeback
  logic [15:0] mdl_cnt;

  function automatic logic [10:0] model_out();
    ins_t e = hist[0];
    ins_t m = hist[1];
    ins_t w = hist[2];
    return {e.v && m.v && (e.ra1 == m.wa3), e.v && w.v && (e.ra1 == w.wa3),
            e.v && m.v && (e.ra2 == m.wa3), e.v && w.v && (e.ra2 == w.wa3),
            ValidD && e.v && ((RA1D == e.wa3) || (RA2D == e.wa3)),
            m.v && m.rw, w.v && w.rw, e.v && e.mr,
            LDRstall, LDRstall, LDRstall || BranchTakenE};
  endfunction

  function automatic void model_step();
    if (reset) begin
      foreach (hist[i]) hist[i] = '0;
      mdl_cnt = 16'd0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (LDRstall || BranchTakenE) hist[0] = '0;
      else hist[0] = '{v: ValidD, ra1: RA1D, ra2: RA2D, wa3: WA3D, rw: RegWriteD, mr: MemtoRegD};
      if (LDRstall && (mdl_cnt != 16'hFFFF)) mdl_cnt = mdl_cnt + 16'd1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] ra1, ra2, wa3,
                       input logic vd, rw, mr, ldr, bt);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    ValidD = vd; RegWriteD = rw; MemtoRegD = mr;
    LDRstall = ldr; BranchTakenE = bt;
  endtask

  typedef struct {
    logic [3:0]  ra1, ra2, wa3;
    logic        vd, rw, mr, ldr, bt;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ra1, ra2, wa3,
                              input logic vd, rw, mr, ldr, bt,
                              input logic [10:0] exp);
    vec_t r;
    r.ra1 = ra1; r.ra2 = ra2; r.wa3 = wa3;
    r.vd = vd; r.rw = rw; r.mr = mr; r.ldr = ldr; r.bt = bt;
    r.exp = exp;
    return r;
  endfunction

  vec_t tbl[25];

  initial begin
    // Idle after reset: all-zero addresses with ValidD=0 must never match.
    for (int i = 0; i < 5; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0000_000);
    // Write r3, then two readers of r3: D/E, then E/M, then E/W hits.
    tbl[5]  = mk(0, 0, 3, 1, 1, 0, 0, 0, 11'b0000_0000_000);
    tbl[6]  = mk(3, 9, 7, 1, 0, 0, 0, 0, 11'b0000_1000_000);
    tbl[7]  = mk(3, 9, 7, 1, 0, 0, 0, 0, 11'b1000_0100_000);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0100_0010_000);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0000_000);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0000_000);
    // Load r5, dependent reader stalls one cycle, E bubble, then E/W hit.
    tbl[11] = mk(1, 2, 5, 1, 1, 1, 0, 0, 11'b0000_0000_000);
    tbl[12] = mk(4, 5, 6, 1, 1, 0, 1, 0, 11'b0000_1001_111);
    tbl[13] = mk(4, 5, 6, 1, 1, 0, 0, 0, 11'b0000_0100_000);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0001_0010_000);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0100_000);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0010_000);
    // Branch flush squashes a valid writer in D.
    tbl[17] = mk(8, 8, 8, 1, 1, 0, 0, 1, 11'b0000_0000_001);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0000_000);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0000_000);
    // Stall and branch together: one bubble, writer ahead keeps flowing.
    tbl[20] = mk(0, 0, 2, 1, 1, 0, 0, 0, 11'b0000_0000_000);
    tbl[21] = mk(2, 0, 0, 1, 0, 0, 1, 1, 11'b0000_1000_111);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0100_000);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0010_000);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_0000_000);

    foreach (hist[i]) hist[i] = '0;
    mdl_cnt = 16'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    #4;
    check("reset_outs", {5'd0, outs}, 16'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wa3, tbl[i].vd, tbl[i].rw,
            tbl[i].mr, tbl[i].ldr, tbl[i].bt);
      #4;
      check($sformatf("table[%0d]", i), {5'd0, outs}, {5'd0, tbl[i].exp});
      tick();
    end

    // Mid-operation reset drains a busy pipe: nothing may match afterwards.
    drive(1, 1, 1, 1, 1, 1, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    #4;
    check("after_mid_reset", {5'd0, outs}, 16'd0);
    tick();

    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) == 0);
      drive(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0));
      #4;
      check($sformatf("rand[%0d]", c), {5'd0, outs}, {5'd0, model_out()});
`ifdef HAZARD_STALL_CNT_EN
      check($sformatf("rand_cnt[%0d]", c), StallCount, mdl_cnt);
`endif
      tick();
    end
    reset = 1'b0;

`ifdef HAZARD_STALL_CNT_EN
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      LDRstall = 1'b1;
      tick();
    end
    LDRstall = 1'b0;
    #4;
    check("stall_cnt_3", StallCount, 16'd3);
    tick();
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    mdl_cnt = 16'hFFFF;
    LDRstall = 1'b1;
    tick();
    tick();
    LDRstall = 1'b0;
    #4;
    check("stall_cnt_sat", StallCount, 16'hFFFF);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_match_pipe.md
# hazard_match_pipe

Register-tag pipeline that sits directly upstream of the hazard unit in the 5-stage core. It carries source/destination register addresses and the write/load control bits from Decode through Execute, Memory and Writeback. It produces the `Match_*` comparison flags, plus `RegWriteM`, `RegWriteW` and `MemtoRegE`, which the hazard unit consumes. It applies the hazard unit's `LDRstall` (and a branch flush) to its own Execute slot so that the tags stay aligned with the datapath pipeline registers.

## Interface
- `REG_ADDR_W`, 4: register address width (16-entry file).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `RA1D`  in  REG_ADDR_W  Decode source 1 address.
- `RA2D`  in  REG_ADDR_W  Decode source 2 address.
- `WA3D`  in  REG_ADDR_W  Decode destination address.
- `ValidD`  in  1  Decode holds a real instruction.
- `RegWriteD`  in  1  Decode instruction writes the register file.
- `MemtoRegD`  in  1  Decode instruction is a load.
- `LDRstall`  in  1  from hazard unit; load-use stall request.
- `BranchTakenE`  in  1  branch resolved taken in Execute.
- `Match_1E_M`, `Match_1E_W`, `Match_2E_M`, `Match_2E_W`  out  1 each  E-source vs M/W destination hits.
- `Match_12D_E`  out  1  either D source equals E destination.
- `RegWriteM`, `RegWriteW`, `MemtoRegE`  out  1 each  delayed control.
- `StallF`, `StallD`, `FlushE`  out  1 each  pipeline-register controls.

## Operation
- Per-stage state:
  - E: `ValidE`, `RA1E`, `RA2E`, `WA3E`, `RegWriteE`, `MemtoRegE`.
  - M: `ValidM`, `WA3M`, `RegWriteM`, `MemtoRegM`.
  - W: `ValidW`, `WA3W`, `RegWriteW`.
- Bubble: all stage fields zero, valid 0.
- `StallF = StallD = LDRstall`; `FlushE = LDRstall | BranchTakenE`.
- Every cycle, M <= E and W <= M unconditionally. The pipeline never freezes beyond Decode.
- E slot update:
  - If `FlushE`, E <= bubble.
  - Otherwise E <= D fields, with `ValidE = ValidD`. `RegWriteE` and `MemtoRegE` are ANDed with `ValidD`.
- Match flags (combinational from registered state and D inputs):
  - `Match_1E_M = ValidE & ValidM & (RA1E == WA3M)`; the other three E/M/W flags follow the same pattern.
  - `Match_12D_E = ValidD & ValidE & ((RA1D == WA3E) | (RA2D == WA3E))`.
- A flushed or reset stage never produces a match or a write. Valid-gating keeps all-zero bubbles from aliasing register 0.
- Simultaneous `LDRstall` and `BranchTakenE`: a single bubble is inserted into E. Decode is still held for that cycle.
- Back-to-back `LDRstall` cycles each insert one bubble. Decode inputs are expected to be held by the stalled Decode register.

## Timing
- Latency D to E, E to M, M to W: one cycle each.
- `RegWriteW` asserts 3 cycles after a valid, unstalled `RegWriteD` is sampled.
- `StallF`, `StallD` and `FlushE` are purely combinational from their inputs (zero latency). `LDRstall` originates from registered E state plus D inputs, so no combinational loop exists.
- Reset: every stage becomes a bubble on the first rising edge with `reset` high.
  - All match flags, `RegWriteM`, `RegWriteW` and `MemtoRegE` read 0 from the following cycle onward.
  - `StallF`, `StallD` and `FlushE` follow their inputs.
- Reset mid-operation discards all in-flight tags; no partial state is retained.

## Configuration
- `HAZARD_STALL_CNT_EN` defined:
  - Adds output `StallCount` (16-bit), which increments on each cycle with `LDRstall` high.
  - The counter saturates at 0xFFFF and does not wrap.
  - Cleared by `reset`.
- Not defined: port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `hazard_pkg`:
  - `REG_ADDR_W` default constant.
  - Packed struct typedefs `tag_e_t`, `tag_m_t`, `tag_w_t`.
  - Bubble constants `TAG_E_BUBBLE`, `TAG_M_BUBBLE`, `TAG_W_BUBBLE`.
- One sub-module, `hazard_tag_cmp`: valid-gated address equality comparator, instantiated five times (four E/M/W flags, one combined D/E flag).

## Test plan
- Reset held 2 cycles, then released with `ValidD=0` → all outputs 0 for 5 cycles.
- Issue WA3D=3, RegWriteD=1, then RA1D=3 next cycle → `Match_1E_M=1` one cycle later, then `Match_1E_W=1` the cycle after.
- Load WA3D=5, MemtoRegD=1, followed by RA2D=5 → `Match_12D_E=1` and `MemtoRegE=1`. Drive `LDRstall=1` → `StallD=1` and `FlushE=1`; next cycle `ValidE=0` and all E-source matches are 0.
- All addresses 0 with `ValidD=0` for 4 cycles → no match flag ever asserts.
- `BranchTakenE=1` with a valid RegWrite in D → E is a bubble, and `RegWriteM` stays 0 the following cycle.
- With `HAZARD_STALL_CNT_EN`: 3 `LDRstall` cycles → `StallCount=3`; forced to 0xFFFF then stalled → remains 0xFFFF.
